regalu_sequencer: RTL and testbench

//  Micro-sequencer driving the RegFile_Alu datapath from a small program ROM.
//  On Start it fetches 24-bit control words and decodes them into RdestRegLoc/RsrcRegLoc/OpCode/Imm/Imm_s/En.
//  It executes one datapath op per word and stops on a HALT word.

---
 rtl/regalu_seq_pkg.sv | 52 +++++
 rtl/regalu_seq_decode.sv | 36 +++
 rtl/regalu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_regalu_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regalu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regalu_seq_pkg
//  Description : Shared definitions for the RegFile_Alu micro-sequencer:
//                FSM state encoding, control-word ctrl codes, control-word
//                field positions, flag index constants and the Imm8 sign
//                extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package regalu_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_DONE    = 3'd4,
        S_FAULT   = 3'd5
    } seq_state_t;

    // ctrl field codes
    localparam logic [1:0] c_CTRL_OP     = 2'b00;
    localparam logic [1:0] c_CTRL_HALT   = 2'b01;
    localparam logic [1:0] c_CTRL_BRANCH = 2'b10;
    localparam logic [1:0] c_CTRL_RSVD   = 2'b11;

    // Control word layout:
    // [23:20] OpCode [19:16] Rdest [15:12] Rsrc [11] Imm_s [10] Wen [9:8] ctrl [7:0] Imm8
    localparam int c_WORD_W    = 24;
    localparam int c_OPC_LSB   = 20;
    localparam int c_RDEST_LSB = 16;
    localparam int c_RSRC_LSB  = 12;
    localparam int c_IMMS_BIT  = 11;
    localparam int c_WEN_BIT   = 10;
    localparam int c_CTRL_LSB  = 8;
    localparam int c_IMM8_LSB  = 0;

    // RegFile_Alu flag vector bit positions
    localparam int c_FLAGS_W = 5;
    localparam int c_FLAG_C  = 0;
    localparam int c_FLAG_L  = 1;
    localparam int c_FLAG_F  = 2;
    localparam int c_FLAG_Z  = 3;
    localparam int c_FLAG_N  = 4;

    function automatic logic [15:0] f_sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/regalu_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module      : regalu_seq_decode
//  Description : Combinational split of a 24-bit sequencer control word.
//                Sign-extends Imm8 to 16 bits and masks the write enable so
//                only OP words can request a register-file write.
//  Ports       : i_word   - control word from program ROM
//                o_opcode / o_rdest / o_rsrc - datapath fields
//                o_imm    - sign-extended immediate, o_imm_s - imm select
//                o_wen    - write enable (OP words only), o_ctrl - ctrl code
//  Revision    : 1.0 - initial release
// ============================================================================
module regalu_seq_decode
    import regalu_seq_pkg::*;
(
    input  logic [c_WORD_W-1:0] i_word,
    output logic [3:0]          o_opcode,
    output logic [3:0]          o_rdest,
    output logic [3:0]          o_rsrc,
    output logic [15:0]         o_imm,
    output logic                o_imm_s,
    output logic                o_wen,
    output logic [1:0]          o_ctrl
);

    assign o_opcode = i_word[c_OPC_LSB +: 4];
    assign o_rdest  = i_word[c_RDEST_LSB +: 4];
    assign o_rsrc   = i_word[c_RSRC_LSB +: 4];
    assign o_imm    = f_sext8(i_word[c_IMM8_LSB +: 8]);
    assign o_imm_s  = i_word[c_IMMS_BIT];
    assign o_ctrl   = i_word[c_CTRL_LSB +: 2];
    // HALT/BRANCH/reserved words never write, whatever their Wen bit says
    assign o_wen    = i_word[c_WEN_BIT] && (o_ctrl == c_CTRL_OP);

endmodule
`default_nettype wire

// File: rtl/regalu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regalu_sequencer
//  Description : Micro-sequencer driving RegFile_Alu from a synchronous
//                program ROM. Each word runs FETCH -> DECODE -> EXECUTE
//                (3 cycles); a HALT word ends the run with a Done pulse,
//                a reserved word or the step watchdog ends it in FAULT.
//  Config      : REGALU_SEQ_BRANCH_EN - enables conditional BRANCH words;
//                when undefined BRANCH is treated as reserved.
//  Parameters  : ADDR_W (ROM address width), MAX_STEPS (watchdog, 1..65535)
//  Ports       : Clk, Rst (async, active-low), Start, Busy, Done, Fault,
//                PcOut/InstrIn (ROM), RdestRegLoc, RsrcRegLoc, OpCode, Imm,
//                Imm_s, En (to RegFile_Alu), Flags (from RegFile_Alu),
//                FlagReg (flags captured at each retiring write)
//  Revision    : 1.0 - initial release
// ============================================================================
module regalu_sequencer
    import regalu_seq_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int MAX_STEPS = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Fault,
    output logic [ADDR_W-1:0] PcOut,
    input  logic [23:0]       InstrIn,
    output logic [3:0]        RdestRegLoc,
    output logic [3:0]        RsrcRegLoc,
    output logic [3:0]        OpCode,
    output logic [15:0]       Imm,
    output logic              Imm_s,
    output logic              En,
    input  logic [4:0]        Flags,
    output logic [4:0]        FlagReg
);

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [15:0]       r_step, w_step_inc;
    logic              r_busy, r_done, r_fault, r_en, r_imm_s;
    logic [3:0]        r_rdest, r_rsrc, r_opcode;
    logic [15:0]       r_imm;
    logic [4:0]        r_flagreg;
    logic [1:0]        r_ctrl;
    logic              w_accept, w_illegal, w_taken;

    logic [3:0]        w_dec_opcode, w_dec_rdest, w_dec_rsrc;
    logic [15:0]       w_dec_imm;
    logic              w_dec_imm_s, w_dec_wen;
    logic [1:0]        w_dec_ctrl;

    regalu_seq_decode u_decode (
        .i_word   (InstrIn),
        .o_opcode (w_dec_opcode),
        .o_rdest  (w_dec_rdest),
        .o_rsrc   (w_dec_rsrc),
        .o_imm    (w_dec_imm),
        .o_imm_s  (w_dec_imm_s),
        .o_wen    (w_dec_wen),
        .o_ctrl   (w_dec_ctrl)
    );

`ifdef REGALU_SEQ_BRANCH_EN
    // Widened so any Rsrc[2:0] indexes a defined bit; indices 5..7 are
    // covered by the Rsrc>=5 "always taken" term anyway.
    logic [7:0] w_flag8;
    assign w_flag8 = {3'b000, r_flagreg};
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step_inc  = r_step + 16'd1;
        w_illegal   = (r_ctrl == c_CTRL_RSVD);
        w_taken     = 1'b0;
`ifdef REGALU_SEQ_BRANCH_EN
        // FlagReg still holds the value from before this word (BRANCH never writes)
        w_taken     = (r_ctrl == c_CTRL_BRANCH) &&
                      ((r_rsrc >= 4'd5) || w_flag8[r_rsrc[2:0]]);
`else
        w_illegal   = w_illegal || (r_ctrl == c_CTRL_BRANCH);
`endif
        w_pc_next   = w_taken ? ADDR_W'(r_imm[7:0]) : r_pc + ADDR_W'(1);

        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH:   w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                // HALT wins over the watchdog when it is the last allowed step
                if (r_ctrl == c_CTRL_HALT)
                    w_state_nxt = S_DONE;
                else if (w_illegal || (w_step_inc == 16'(MAX_STEPS)))
                    w_state_nxt = S_FAULT;
                else
                    w_state_nxt = S_FETCH;
            end
            S_DONE, S_FAULT: begin
                if (Start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = (r_state == S_DONE) ? S_IDLE : S_FAULT;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc      <= '0;
            r_step    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_en      <= 1'b0;
            r_rdest   <= '0;
            r_rsrc    <= '0;
            r_opcode  <= '0;
            r_imm     <= '0;
            r_imm_s   <= 1'b0;
            r_flagreg <= '0;
            r_ctrl    <= c_CTRL_OP;
        end else begin
            // Status outputs are registered from the next state so they are glitch-free
            r_busy <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DECODE) ||
                      (w_state_nxt == S_EXECUTE);
            r_done <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_pc    <= '0;
                r_step  <= '0;
                r_fault <= 1'b0;
            end

            if (r_state == S_DECODE) begin
                r_rdest  <= w_dec_rdest;
                r_rsrc   <= w_dec_rsrc;
                r_opcode <= w_dec_opcode;
                r_imm    <= w_dec_imm;
                r_imm_s  <= w_dec_imm_s;
                r_ctrl   <= w_dec_ctrl;
                r_en     <= w_dec_wen;
            end

            if (r_state == S_EXECUTE) begin
                if (r_en) r_flagreg <= Flags;
                r_en   <= 1'b0;
                r_step <= w_step_inc;
                if (w_state_nxt == S_FETCH) r_pc    <= w_pc_next;
                if (w_state_nxt == S_FAULT) r_fault <= 1'b1;
            end
        end
    end

    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Fault       = r_fault;
    assign PcOut       = r_pc;
    assign RdestRegLoc = r_rdest;
    assign RsrcRegLoc  = r_rsrc;
    assign OpCode      = r_opcode;
    assign Imm         = r_imm;
    assign Imm_s       = r_imm_s;
    assign En          = r_en;
    assign FlagReg     = r_flagreg;

endmodule
`default_nettype wire

// File: tb/tb_regalu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regalu_sequencer
//  Description : Scoreboard bench for regalu_sequencer with a synchronous ROM
//                model and a toy RegFile_Alu (ADD of Imm into Rdest, N/Z
//                flags). Stimulus pushes expected write/done/fault events,
//                a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regalu_sequencer;

    localparam int ADDR_W    = 3;
    localparam int MAX_STEPS = 4;
    localparam int K_WR      = 0;
    localparam int K_DONE    = 1;
    localparam int K_FAULT   = 2;

    typedef struct {
        int kind;
        int cyc;
        int pc;
        int rd;
        int imm;
    } ev_t;

    logic              Clk   = 1'b0;
    logic              Rst   = 1'b0;
    logic              Start = 1'b0;
    logic              Busy, Done, Fault, En, Imm_s;
    logic [ADDR_W-1:0] PcOut;
    logic [23:0]       InstrIn = 24'h0;
    logic [3:0]        RdestRegLoc, RsrcRegLoc, OpCode;
    logic [15:0]       Imm;
    logic [4:0]        Flags, FlagReg;

    logic [23:0] rom  [8];
    logic [15:0] regs [16] = '{default: 16'h0};
    logic [15:0] w_alu_res;
    int          cyc     = 0;
    int          wcount  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        fault_q = 1'b0;
    ev_t         sb[$];

    regalu_sequencer #(.ADDR_W(ADDR_W), .MAX_STEPS(MAX_STEPS)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .Done(Done),
        .Fault(Fault), .PcOut(PcOut), .InstrIn(InstrIn),
        .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc), .OpCode(OpCode),
        .Imm(Imm), .Imm_s(Imm_s), .En(En), .Flags(Flags), .FlagReg(FlagReg)
    );

    always #5 Clk = ~Clk;

    // ROM, register file and cycle counter models
    assign w_alu_res = regs[RdestRegLoc] + Imm;
    assign Flags     = {w_alu_res[15], (w_alu_res == 16'd0), 3'b000};

    always @(posedge Clk) begin
        cyc     <= cyc + 1;
        InstrIn <= rom[PcOut];
        if (En) begin
            regs[RdestRegLoc] <= w_alu_res;
            wcount            <= wcount + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int pc, input int rd, input int imm);
        ev_t e;
        e.kind = kind; e.cyc = c; e.pc = pc; e.rd = rd; e.imm = imm;
        sb.push_back(e);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = sb.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (kind == K_WR) begin
            check("write_pc", 32'(PcOut), e.pc);
            check("write_rdest", 32'(RdestRegLoc), e.rd);
            check("write_imm", 32'(Imm), e.imm);
        end else begin
            check("busy_at_end", 32'(Busy), 0);
        end
    endtask

    // Monitor
    always @(negedge Clk) begin
        if (Rst) begin
            if (En)               expect_ev(K_WR);
            if (Done)             expect_ev(K_DONE);
            if (Fault && !fault_q) expect_ev(K_FAULT);
        end
        fault_q <= Fault;
    end

    function automatic logic [23:0] wd(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic ims, input logic wen,
                                       input logic [1:0] ctrl, input logic [7:0] i8);
        return {op, rd, rs, ims, wen, ctrl, i8};
    endfunction

    function automatic logic [23:0] halt_w();
        return wd(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01, 8'h00);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = halt_w();
    endtask

    // ADD R0,#1 ; ADD R1,#2 ; HALT
    task automatic load_test1();
        clear_rom();
        rom[0] = wd(4'h5, 4'd0, 4'd0, 1'b1, 1'b1, 2'b00, 8'h01);
        rom[1] = wd(4'h5, 4'd1, 4'd0, 1'b1, 1'b1, 2'b00, 8'h02);
    endtask

    // Word k's write is seen at accept+3k+2; Done at accept+3*words.
    task automatic push_test1(input int e);
        push_ev(K_WR,   e + 2, 0, 0, 16'h0001);
        push_ev(K_WR,   e + 5, 1, 1, 16'h0002);
        push_ev(K_DONE, e + 9, 0, 0, 0);
    endtask

    // Returns the cycle count of the edge that accepted Start
    task automatic start_run(output int e);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        e     = cyc;
        Start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(Done || Fault) && n < 60) begin
            @(negedge Clk);
            n++;
        end
        check("run_finished", 32'(Done || Fault), 1);
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int wc;
        int n;

        clear_rom();
        repeat (3) @(negedge Clk);
        check("rst_busy",    32'(Busy), 0);
        check("rst_done",    32'(Done), 0);
        check("rst_fault",   32'(Fault), 0);
        check("rst_en",      32'(En), 0);
        check("rst_flagreg", 32'(FlagReg), 0);
        check("rst_imm",     32'(Imm), 0);
        check("rst_pcout",   32'(PcOut), 0);
        check("rst_rdest",   32'(RdestRegLoc), 0);
        Rst = 1'b1;

        // Reset during EXECUTE of a writing word aborts with no write
        load_test1();
        start_run(e);
        push_ev(K_WR, e + 2, 0, 0, 16'h0001);
        n = 0;
        while (!En && n < 10) begin
            @(negedge Clk);
            n++;
        end
        check("abort_en_seen", 32'(En), 1);
        #1;
        wc  = wcount;
        Rst = 1'b0;
        #1;
        check("abort_en",    32'(En), 0);
        check("abort_busy",  32'(Busy), 0);
        check("abort_pcout", 32'(PcOut), 0);
        @(posedge Clk);
        #1;
        check("abort_no_write", wcount, wc);
        check("abort_en_hold",  32'(En), 0);
        @(negedge Clk);
        Rst = 1'b1;

        // Basic two-write program
        start_run(e);
        push_test1(e);
        wait_end();

        // Start pulses while busy must not disturb the run
        start_run(e);
        push_test1(e);
        repeat (3) @(negedge Clk);
        check("busy_mid_run", 32'(Busy), 1);
        Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        wait_end();

        // Watchdog: no HALT, MAX_STEPS=4; word 1 has Wen=0
        clear_rom();
        rom[0] = wd(4'h5, 4'd2, 4'd0, 1'b1, 1'b1, 2'b00, 8'h80);
        rom[1] = wd(4'h5, 4'd3, 4'd0, 1'b1, 1'b0, 2'b00, 8'h7F);
        rom[2] = wd(4'h5, 4'd4, 4'd0, 1'b1, 1'b1, 2'b00, 8'hFE);
        rom[3] = wd(4'h5, 4'd7, 4'd0, 1'b1, 1'b1, 2'b00, 8'h01);
        rom[4] = wd(4'h5, 4'd8, 4'd0, 1'b1, 1'b1, 2'b00, 8'h03);
        start_run(e);
        push_ev(K_WR,    e + 2,  0, 2, 16'hFF80);
        push_ev(K_WR,    e + 8,  2, 4, 16'hFFFE);
        push_ev(K_WR,    e + 11, 3, 7, 16'h0001);
        push_ev(K_FAULT, e + 12, 0, 0, 0);
        wait_end();
        check("wd_fault_sticky", 32'(Fault), 1);
        check("wd_busy",         32'(Busy), 0);

        // Next Start clears Fault
        load_test1();
        start_run(e);
        check("fault_cleared", 32'(Fault), 0);
        push_test1(e);
        wait_end();

        // ADD R5,#0 (Z=1) ; BRANCH on FlagReg[3] to 7 ; word 7 ADD R2,#0x7F ; wrap to 0
        clear_rom();
        rom[0] = wd(4'h5, 4'd5, 4'd0, 1'b1, 1'b1, 2'b00, 8'h00);
        rom[1] = wd(4'h0, 4'd0, 4'd3, 1'b0, 1'b1, 2'b10, 8'h07);
        rom[2] = wd(4'h5, 4'd6, 4'd0, 1'b1, 1'b1, 2'b00, 8'h09);
        rom[7] = wd(4'h5, 4'd2, 4'd0, 1'b1, 1'b1, 2'b00, 8'h7F);
        start_run(e);
        push_ev(K_WR, e + 2, 0, 5, 16'h0000);
`ifdef REGALU_SEQ_BRANCH_EN
        push_ev(K_WR,   e + 8,  7, 2, 16'h007F);
        push_ev(K_DONE, e + 12, 0, 0, 0);
`else
        push_ev(K_FAULT, e + 6, 0, 0, 0);
`endif
        // Word 0 has been read for this run; it becomes HALT for the wrap-around
        repeat (2) @(posedge Clk);
        rom[0] = halt_w();
        wait_end();
`ifdef REGALU_SEQ_BRANCH_EN
        check("br_flagreg", 32'(FlagReg), 32'h10);
        check("br_pc_wrap", 32'(PcOut), 0);
`else
        check("br_flagreg", 32'(FlagReg), 32'h08);
        check("br_pc_fault", 32'(PcOut), 1);
        check("br_fault", 32'(Fault), 1);
`endif

        repeat (2) @(negedge Clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
